// File: rtl/branch_resolve_unit_pkg.sv
// Shared encodings for the branch resolve unit: condition codes, branch kinds
// and BHT counter states, plus the saturating counter step.
package branch_resolve_unit_pkg;

   typedef enum logic [3:0] {
      COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
      COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
      COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
      COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
   } cond_t;

   typedef enum logic [2:0] {
      BK_NONE  = 3'd0,
      BK_B     = 3'd1,
      BK_BCOND = 3'd2,
      BK_CBZ   = 3'd3,
      BK_CBNZ  = 3'd4,
      BK_BR    = 3'd5
   } bk_t;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } cnt_t;

   function automatic logic [1:0] bht_next(input logic [1:0] cur, input logic taken);
      logic [1:0] nxt;
      nxt = cur;
      if (taken) begin
         if (cur != ST) nxt = cur + 2'd1;
      end else begin
         if (cur != SNT) nxt = cur - 2'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/branch_resolve_unit_cond_eval.sv
// Combinational condition-code evaluator: 4-bit condition and NZCV in, taken out.
module cond_eval
   import branch_resolve_unit_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       taken
);

   logic n, z, c, v, ge;

   always_comb begin
      n     = nzcv[3];
      z     = nzcv[2];
      c     = nzcv[1];
      v     = nzcv[0];
      ge    = (n == v);
      taken = 1'b1;
      case (cond)
         COND_EQ: taken = z;
         COND_NE: taken = ~z;
         COND_CS: taken = c;
         COND_CC: taken = ~c;
         COND_MI: taken = n;
         COND_PL: taken = ~n;
         COND_VS: taken = v;
         COND_VC: taken = ~v;
         COND_HI: taken = c & ~z;
         COND_LS: taken = ~(c & ~z);
         COND_GE: taken = ge;
         COND_LT: taken = ~ge;
         COND_GT: taken = ~z & ge;
         COND_LE: taken = ~(~z & ge);
         default: taken = 1'b1;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: owns NZCV, resolves B/B.cond/CBZ/CBNZ/BR with one cycle
// of latency, and keeps a PC-indexed 2-bit BHT plus saturating statistics.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned PC_W      = 64,
   parameter int unsigned BHT_DEPTH = 64,
   parameter logic [1:0]  CNT_INIT  = 2'b01,
   parameter int unsigned STAT_W    = 32
) (
   input  logic              iCLK,
   input  logic              iRST_n,
   input  logic              iFlagWe,
   input  logic              iFlagN,
   input  logic              iFlagZ,
   input  logic              iFlagC,
   input  logic              iFlagV,
   input  logic              iValid,
   input  logic [2:0]        iBrKind,
   input  logic [3:0]        iCond,
   input  logic [DATA_W-1:0] iRegVal,
   input  logic [PC_W-1:0]   iPC,
   input  logic              iPredTaken,
   input  logic [PC_W-1:0]   iFetchPC,
   output logic              oPredTaken,
   output logic [3:0]        oFlags,
   output logic              oResValid,
   output logic              oTaken,
   output logic              oMispredict,
   output logic [STAT_W-1:0] oBrCount,
   output logic [STAT_W-1:0] oMissCount
);

   localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

   logic [3:0]        flags_q;
   logic [3:0]        in_flags;
   logic [3:0]        eval_flags;
   logic              cond_taken;
   logic [1:0]        bht [BHT_DEPTH];
   logic [IDX_W-1:0]  idx_fetch;
   logic [IDX_W-1:0]  idx_res;
   logic              is_branch;
   logic              bht_upd;
   logic              dir;
   logic              res_valid_q;
   logic              taken_q;
   logic              pred_q;
   logic [STAT_W-1:0] br_q;
   logic [STAT_W-1:0] miss_q;
   logic              unused_pc_bits;

   assign in_flags   = {iFlagN, iFlagZ, iFlagC, iFlagV};
   // Same-cycle flag write is forwarded so B.cond sees the flags it depends on.
   assign eval_flags = iFlagWe ? in_flags : flags_q;
   assign idx_fetch  = iFetchPC[IDX_W+1:2];
   assign idx_res    = iPC[IDX_W+1:2];

   assign unused_pc_bits = ^{iPC[PC_W-1:IDX_W+2], iPC[1:0],
                             iFetchPC[PC_W-1:IDX_W+2], iFetchPC[1:0]};

   cond_eval u_cond_eval (
      .cond  (iCond),
      .nzcv  (eval_flags),
      .taken (cond_taken)
   );

   always_comb begin
      is_branch = 1'b0;
      bht_upd   = 1'b0;
      dir       = 1'b0;
      if (iValid) begin
         case (iBrKind)
            BK_B, BK_BR: begin
               is_branch = 1'b1;
               dir       = 1'b1;
            end
            BK_BCOND: begin
               is_branch = 1'b1;
               bht_upd   = 1'b1;
               dir       = cond_taken;
            end
            BK_CBZ: begin
               is_branch = 1'b1;
               bht_upd   = 1'b1;
               dir       = (iRegVal == '0);
            end
            BK_CBNZ: begin
               is_branch = 1'b1;
               bht_upd   = 1'b1;
               dir       = (iRegVal != '0);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         flags_q     <= '0;
         res_valid_q <= 1'b0;
         taken_q     <= 1'b0;
         pred_q      <= 1'b0;
         br_q        <= '0;
         miss_q      <= '0;
         for (int unsigned i = 0; i < BHT_DEPTH; i++) bht[i] <= CNT_INIT;
      end else begin
         if (iFlagWe) flags_q <= in_flags;
         res_valid_q <= is_branch;
         taken_q     <= is_branch & dir;
         pred_q      <= is_branch & iPredTaken;
         if (bht_upd) begin
            bht[idx_res] <= bht_next(bht[idx_res], dir);
            if (br_q != '1) br_q <= br_q + 1'b1;
            if ((dir != iPredTaken) && (miss_q != '1)) miss_q <= miss_q + 1'b1;
         end
      end
   end

   assign oPredTaken  = bht[idx_fetch][1];
   assign oFlags      = flags_q;
   assign oResValid   = res_valid_q;
   assign oTaken      = taken_q;
   assign oMispredict = res_valid_q & (taken_q != pred_q);
   assign oBrCount    = br_q;
   assign oMissCount  = miss_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a driver pushes expected per-cycle
// outputs from a behavioural model; a monitor pops and compares after each edge.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flag_we, fn, fz, fc, fv;
   logic        valid;
   logic [2:0]  kind;
   logic [3:0]  cond;
   logic [63:0] regval, pc, fetch_pc;
   logic        pred_in;

   logic        pred_taken, res_valid, taken, mis;
   logic [3:0]  flags;
   logic [31:0] br_cnt, miss_cnt;
   logic        s_pred_taken, s_res_valid, s_taken, s_mis;
   logic [3:0]  s_flags;
   logic [1:0]  s_br_cnt, s_miss_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   branch_resolve_unit u_dut (
      .iCLK(clk), .iRST_n(rst_n), .iFlagWe(flag_we),
      .iFlagN(fn), .iFlagZ(fz), .iFlagC(fc), .iFlagV(fv),
      .iValid(valid), .iBrKind(kind), .iCond(cond), .iRegVal(regval),
      .iPC(pc), .iPredTaken(pred_in), .iFetchPC(fetch_pc),
      .oPredTaken(pred_taken), .oFlags(flags), .oResValid(res_valid),
      .oTaken(taken), .oMispredict(mis), .oBrCount(br_cnt), .oMissCount(miss_cnt)
   );

   branch_resolve_unit #(.STAT_W(2)) u_small (
      .iCLK(clk), .iRST_n(rst_n), .iFlagWe(flag_we),
      .iFlagN(fn), .iFlagZ(fz), .iFlagC(fc), .iFlagV(fv),
      .iValid(valid), .iBrKind(kind), .iCond(cond), .iRegVal(regval),
      .iPC(pc), .iPredTaken(pred_in), .iFetchPC(fetch_pc),
      .oPredTaken(s_pred_taken), .oFlags(s_flags), .oResValid(s_res_valid),
      .oTaken(s_taken), .oMispredict(s_mis), .oBrCount(s_br_cnt), .oMissCount(s_miss_cnt)
   );

   typedef struct {
      bit        v;
      bit        t;
      bit        m;
      bit [3:0]  f;
      bit [31:0] br;
      bit [31:0] miss;
      bit [1:0]  sbr;
      bit [1:0]  smiss;
   } exp_t;

   exp_t    q[$];
   bit [1:0] m_bht [64];
   bit [3:0] m_flags;
   longint   m_br, m_miss;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int idx(input logic [63:0] p);
      return int'((p >> 2) % 64);
   endfunction

   function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return cy;
         4'h3: return !cy;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return cy && !z;
         4'h9: return !(cy && !z);
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return !(!z && (n == v));
         default: return 1'b1;
      endcase
   endfunction

   function automatic longint sat(input longint x, input longint maxv);
      return (x > maxv) ? maxv : x;
   endfunction

   task automatic model_reset();
      foreach (m_bht[i]) m_bht[i] = 2'b01;
      m_flags = 4'b0000;
      m_br    = 0;
      m_miss  = 0;
   endtask

   // Drive one cycle of inputs (caller is at a negedge), check the lookup, push expectation.
   task automatic drive(input logic we, input logic [3:0] nzcv, input logic v,
                        input logic [2:0] k, input logic [3:0] c, input logic [63:0] rv,
                        input logic [63:0] p, input logic pr, input logic [63:0] fp);
      exp_t     e;
      bit [3:0] eff;
      bit       isbr, cnd, d;
      flag_we = we; {fn, fz, fc, fv} = nzcv; valid = v; kind = k; cond = c;
      regval = rv; pc = p; pred_in = pr; fetch_pc = fp;
      #1;
      chk("pred_lookup", pred_taken, m_bht[idx(fp)][1]);
      eff  = we ? nzcv : m_flags;
      isbr = v && (k >= 3'd1) && (k <= 3'd5);
      cnd  = v && (k >= 3'd2) && (k <= 3'd4);
      case (k)
         3'd2:    d = cond_holds(c, eff);
         3'd3:    d = (rv == 64'd0);
         3'd4:    d = (rv != 64'd0);
         default: d = 1'b1;
      endcase
      if (cnd) begin
         if (d && m_bht[idx(p)] != 2'b11) m_bht[idx(p)]++;
         if (!d && m_bht[idx(p)] != 2'b00) m_bht[idx(p)]--;
         m_br++;
         if (d != pr) m_miss++;
      end
      if (we) m_flags = nzcv;
      e.v     = isbr;
      e.t     = isbr && d;
      e.m     = isbr && (d != pr);
      e.f     = m_flags;
      e.br    = 32'(sat(m_br, 64'hFFFF_FFFF));
      e.miss  = 32'(sat(m_miss, 64'hFFFF_FFFF));
      e.sbr   = 2'(sat(m_br, 3));
      e.smiss = 2'(sat(m_miss, 3));
      q.push_back(e);
   endtask

   task automatic cyc(input logic we, input logic [3:0] nzcv, input logic v,
                      input logic [2:0] k, input logic [3:0] c, input logic [63:0] rv,
                      input logic [63:0] p, input logic pr, input logic [63:0] fp);
      @(negedge clk);
      drive(we, nzcv, v, k, c, rv, p, pr, fp);
   endtask

   task automatic idle(input logic [63:0] fp);
      cyc(1'b0, 4'h0, 1'b0, 3'd0, 4'h0, 64'd1, 64'h0, 1'b0, fp);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      valid = 1'b1; kind = 3'd1; flag_we = 1'b1; {fn, fz, fc, fv} = 4'hF;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_resvalid", res_valid, 0);
      chk("rst_taken", taken, 0);
      chk("rst_mispredict", mis, 0);
      chk("rst_flags", flags, 0);
      chk("rst_brcount", br_cnt, 0);
      chk("rst_misscount", miss_cnt, 0);
      chk("rst_small_miss", s_miss_cnt, 0);
      chk("rst_pred", pred_taken, 0);
      q.delete();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 4'h0, 1'b0, 3'd0, 4'h0, 64'd1, 64'h0, 1'b0, 64'h40);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("res_valid", res_valid, e.v);
            chk("taken", taken, e.t);
            chk("mispredict", mis, e.m);
            chk("flags", flags, e.f);
            chk("br_count", br_cnt, e.br);
            chk("miss_count", miss_cnt, e.miss);
            chk("small_br_count", s_br_cnt, e.sbr);
            chk("small_miss_count", s_miss_cnt, e.smiss);
         end
      end
   end

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      logic [3:0]  sweep [4];
      logic [63:0] rv, p, fp;
      sweep[0] = 4'b0000; sweep[1] = 4'b1001; sweep[2] = 4'b0110; sweep[3] = 4'b0011;
      rst_n = 1'b0;
      flag_we = 0; {fn, fz, fc, fv} = 4'h0; valid = 0; kind = 0; cond = 0;
      regval = 0; pc = 0; pred_in = 0; fetch_pc = 0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 4'h0, 1'b0, 3'd0, 4'h0, 64'd1, 64'h0, 1'b0, 64'h40);

      // EQ taken against weakly-not-taken prediction
      cyc(1'b1, 4'b0100, 1'b0, 3'd0, 4'h0, 64'd1, 64'h0, 1'b0, 64'h40);
      cyc(1'b0, 4'b0000, 1'b1, 3'd2, 4'h0, 64'd1, 64'h40, 1'b0, 64'h40);
      idle(64'h40);

      // same-cycle flag bypass: NE with Z written to 1 in the same cycle
      cyc(1'b1, 4'b0000, 1'b0, 3'd0, 4'h0, 64'd1, 64'h0, 1'b0, 64'h40);
      cyc(1'b1, 4'b0100, 1'b1, 3'd2, 4'h1, 64'd1, 64'h80, 1'b1, 64'h80);
      idle(64'h80);

      // CBZ saturation then CBNZ step down, back to back on one entry
      repeat (3) cyc(1'b0, 4'h0, 1'b1, 3'd3, 4'h0, 64'd0, 64'h40, 1'b1, 64'h40);
      cyc(1'b0, 4'h0, 1'b1, 3'd4, 4'h0, 64'd0, 64'h40, 1'b1, 64'h40);
      idle(64'h40);

      foreach (sweep[s]) begin
         cyc(1'b1, sweep[s], 1'b0, 3'd0, 4'h0, 64'd1, 64'h0, 1'b0, 64'h0);
         for (int c = 0; c < 16; c++)
            cyc(1'b0, 4'h0, 1'b1, 3'd2, 4'(c), 64'd1, 64'(c) << 2, 1'(c & 1), 64'(c) << 2);
      end

      // unconditional kinds, including undefined kind codes
      cyc(1'b0, 4'h0, 1'b1, 3'd1, 4'h0, 64'd5, 64'h100, 1'b0, 64'h100);
      cyc(1'b0, 4'h0, 1'b1, 3'd5, 4'h0, 64'd5, 64'h100, 1'b1, 64'h100);
      cyc(1'b0, 4'h0, 1'b1, 3'd6, 4'h0, 64'd0, 64'h100, 1'b1, 64'h100);
      cyc(1'b0, 4'h0, 1'b1, 3'd7, 4'h0, 64'd0, 64'h100, 1'b1, 64'h100);
      idle(64'h100);

      pulse_reset();
      repeat (5) cyc(1'b0, 4'h0, 1'b1, 3'd2, 4'hE, 64'd1, 64'h200, 1'b0, 64'h200);
      idle(64'h200);

      repeat (300) begin
         rv = ($urandom_range(0, 1) == 0) ? 64'd0 : {$urandom, $urandom};
         p  = (64'($urandom_range(0, 127)) << 2) | (($urandom_range(0, 3) == 0) ? {$urandom, 32'h0} : 64'h0);
         fp = (64'($urandom_range(0, 127)) << 2) | 64'($urandom_range(0, 3));
         cyc($urandom_range(0, 3) == 0, 4'($urandom), $urandom_range(0, 3) != 0,
             3'($urandom_range(0, 7)), 4'($urandom), rv, p, 1'($urandom), fp);
      end
      idle(64'h0);

      @(negedge clk);
      @(negedge clk);
      chk("scoreboard_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
